// File: rtl/spi_eeprom_ctrl_pkg.sv
// Shared encodings for the 25AA02E48 MAC EEPROM SPI sequencer.
package spi_eeprom_ctrl_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_RELEASE = 2'd1;
    localparam logic [1:0] OP_READOUT = 2'd2;
    localparam logic [1:0] OP_XFER    = 2'd3;

    localparam logic [1:0] SM_HOLD  = 2'b00;
    localparam logic [1:0] SM_SHIFT = 2'b01;
    localparam logic [1:0] SM_LOAD  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_HIGH = 3'd2;
    localparam state_t ST_LOW  = 3'd3;
    localparam state_t ST_OUT  = 3'd4;

endpackage

// File: rtl/spi_eeprom_ctrl.sv
// SPI master sequencer for the e48 MAC EEPROM: drives CS, SCK and the external
// shift register controls; carries no data itself.
module spi_eeprom_ctrl #(
    parameter int BITS     = 8,
    parameter int HALF_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] operation,
    output logic       oel,
    output logic [1:0] shiftMode,
    output logic       spi_clk,
    output logic       e48_csl,
    output logic       e48_hold
);
    import spi_eeprom_ctrl_pkg::*;

    localparam int CNT_W = $clog2(BITS + 1);
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [DIV_W-1:0] div, div_next;
    logic             csl_next;
    logic             oel_next;
    logic             sck_next;
    logic [1:0]       sm_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        div_next   = div;
        csl_next   = e48_csl;
        case (state)
            ST_IDLE: begin
                case (operation)
                    OP_NOP:     ;
                    OP_RELEASE: csl_next = 1'b1;
                    OP_READOUT: state_next = ST_OUT;
                    OP_XFER: begin
                        state_next = ST_LOAD;
                        csl_next   = 1'b0;
                    end
                endcase
            end
            ST_LOAD: begin
                state_next = ST_HIGH;
                cnt_next   = '0;
                div_next   = '0;
            end
            ST_HIGH: begin
                if (div == DIV_LAST) begin
                    state_next = ST_LOW;
                    div_next   = '0;
                end else begin
                    div_next = div + DIV_ONE;
                end
            end
            ST_LOW: begin
                if (div == DIV_LAST) begin
                    cnt_next   = cnt + CNT_ONE;
                    div_next   = '0;
                    state_next = (cnt_next == CNT_LAST) ? ST_IDLE : ST_HIGH;
                end else begin
                    div_next = div + DIV_ONE;
                end
            end
            ST_OUT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        oel_next = (state_next != ST_OUT);
        sck_next = (state_next == ST_HIGH);
        sm_next  = SM_HOLD;
        if (state_next == ST_LOAD) begin
            sm_next = SM_LOAD;
        end else if (state_next == ST_LOW && div_next == DIV_LAST) begin
            sm_next = SM_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div       <= '0;
            oel       <= 1'b1;
            shiftMode <= SM_HOLD;
            spi_clk   <= 1'b0;
            e48_csl   <= 1'b1;
            e48_hold  <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            div       <= div_next;
            oel       <= oel_next;
            shiftMode <= sm_next;
            spi_clk   <= sck_next;
            e48_csl   <= csl_next;
            e48_hold  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_eeprom_ctrl.sv
// Bench for spi_eeprom_ctrl: vector table, directed corner sequences and random
// commands checked against a schedule-based reference model.
module tb_spi_eeprom_ctrl;

    localparam int BITS = 8;
    localparam int HD   = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] operation = 2'd0;
    logic       oel;
    logic [1:0] shiftMode;
    logic       spi_clk;
    logic       e48_csl;
    logic       e48_hold;

    always #5 clk = ~clk;

    spi_eeprom_ctrl #(.BITS(BITS), .HALF_DIV(HD)) dut (
        .clk       (clk),
        .reset     (reset),
        .operation (operation),
        .oel       (oel),
        .shiftMode (shiftMode),
        .spi_clk   (spi_clk),
        .e48_csl   (e48_csl),
        .e48_hold  (e48_hold)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each command expands into a per-cycle schedule of expected outputs.
    typedef struct packed {
        logic       busy;
        logic       oel;
        logic [1:0] sm;
        logic       sck;
        logic       csl;
    } rec_t;

    rec_t cur = '{busy: 1'b0, oel: 1'b1, sm: 2'b00, sck: 1'b0, csl: 1'b1};
    rec_t sched[$];

    function automatic rec_t mk(input logic b, input logic o, input logic [1:0] s,
                                input logic k, input logic c);
        rec_t r;
        r.busy = b; r.oel = o; r.sm = s; r.sck = k; r.csl = c;
        return r;
    endfunction

    function automatic void model_edge(input logic r, input logic [1:0] op);
        if (!r) begin
            sched.delete();
            cur = mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        end else if (cur.busy) begin
            if (sched.size() > 0) cur = sched.pop_front();
            else                  cur = mk(1'b0, 1'b1, 2'b00, 1'b0, cur.csl);
        end else begin
            case (op)
                2'd1: cur.csl = 1'b1;
                2'd2: cur = mk(1'b1, 1'b0, 2'b00, 1'b0, cur.csl);
                2'd3: begin
                    sched.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0));
                    for (int b = 0; b < BITS; b++) begin
                        for (int h = 0; h < HD; h++)
                            sched.push_back(mk(1'b1, 1'b1, 2'b00, 1'b1, 1'b0));
                        for (int h = 0; h < HD; h++)
                            sched.push_back(mk(1'b1, 1'b1, (h == HD - 1) ? 2'b01 : 2'b00, 1'b0, 1'b0));
                    end
                    cur = sched.pop_front();
                end
                default: ;
            endcase
        end
    endfunction

    int   rises  = 0;
    int   shifts = 0;
    logic prev_sck = 1'b0;

    task automatic step(input logic r, input logic [1:0] op);
        reset     = r;
        operation = op;
        @(posedge clk);
        model_edge(r, op);
        #1;
        check("cycle", {oel, shiftMode, spi_clk, e48_csl, e48_hold},
              {cur.oel, cur.sm, cur.sck, cur.csl, 1'b1});
        if (spi_clk && !prev_sck) rises++;
        if (shiftMode == 2'b01) shifts++;
        prev_sck = spi_clk;
    endtask

    typedef struct {
        logic       r;
        logic [1:0] op;
        logic [4:0] exp;   // {oel, shiftMode, spi_clk, e48_csl}
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{r: 1'b0, op: 2'd3, exp: 5'b1_00_0_1};
        tbl[1] = '{r: 1'b1, op: 2'd0, exp: 5'b1_00_0_1};
        tbl[2] = '{r: 1'b1, op: 2'd2, exp: 5'b0_00_0_1};
        tbl[3] = '{r: 1'b1, op: 2'd2, exp: 5'b1_00_0_1};
        tbl[4] = '{r: 1'b1, op: 2'd1, exp: 5'b1_00_0_1};
        tbl[5] = '{r: 1'b1, op: 2'd3, exp: 5'b1_10_0_0};
        tbl[6] = '{r: 1'b1, op: 2'd1, exp: 5'b1_00_1_0};
        tbl[7] = '{r: 1'b1, op: 2'd0, exp: 5'b1_01_0_0};

        // reset held 50 cycles, then idle with NOP
        repeat (50) step(1'b0, 2'd3);
        check("rst_vals", {oel, shiftMode, spi_clk, e48_csl, e48_hold}, 6'b1_00_0_1_1);
        repeat (5) step(1'b1, 2'd0);
        check("post_rst", {oel, shiftMode, spi_clk, e48_csl, e48_hold}, 6'b1_00_0_1_1);

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].op);
            check("vec", {oel, shiftMode, spi_clk, e48_csl}, tbl[i].exp);
        end
        repeat (20) step(1'b1, 2'd0);

        // full transfer: LOAD then exactly 17 cycles to IDLE
        rises = 0; shifts = 0;
        step(1'b1, 2'd3);
        check("load_csl", e48_csl, 0);
        check("load_sm", shiftMode, 2);
        repeat (16) step(1'b1, 2'd0);
        step(1'b1, 2'd2);
        check("busy_oel", oel, 1);
        check("xfer_rises", rises, BITS);
        check("xfer_shifts", shifts, BITS);
        step(1'b1, 2'd2);
        check("idle17_oel", oel, 0);
        check("csl_held", e48_csl, 0);
        step(1'b1, 2'd0);

        // second XFER while busy is dropped
        rises = 0;
        step(1'b1, 2'd3);
        step(1'b1, 2'd0);
        step(1'b1, 2'd3);
        repeat (25) step(1'b1, 2'd0);
        check("ignore_rises", rises, BITS);

        // RELEASE 7 cycles into a transfer is dropped
        step(1'b1, 2'd3);
        repeat (6) step(1'b1, 2'd0);
        step(1'b1, 2'd1);
        check("rel_busy_csl", e48_csl, 0);
        repeat (12) step(1'b1, 2'd0);
        check("rel_after_csl", e48_csl, 0);

        // release and readout in IDLE
        rises = 0;
        step(1'b1, 2'd1);
        check("release_csl", e48_csl, 1);
        check("release_sck", spi_clk, 0);
        step(1'b1, 2'd1);
        check("release_again", e48_csl, 1);
        step(1'b1, 2'd2);
        check("readout_oel", oel, 0);
        check("readout_sm", shiftMode, 0);
        step(1'b1, 2'd0);
        check("readout_end", oel, 1);
        check("readout_rises", rises, 0);

        // reset in cycle 5 of a transfer, then a fresh transfer
        step(1'b1, 2'd3);
        repeat (4) step(1'b1, 2'd0);
        step(1'b0, 2'd3);
        check("midrst_vals", {oel, shiftMode, spi_clk, e48_csl, e48_hold}, 6'b1_00_0_1_1);
        step(1'b1, 2'd0);
        rises = 0; shifts = 0;
        step(1'b1, 2'd3);
        repeat (17) step(1'b1, 2'd0);
        check("fresh_rises", rises, BITS);
        check("fresh_shifts", shifts, BITS);
        check("fresh_csl", e48_csl, 0);

        // random commands with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
